compdiv_eq: RTL and testbench

Sequential fixed-point complex divider computing o = a / b in signed Q4.12, used as the per-subcarrier zero-forcing step after the receive FFT: received symbol divided by channel estimate. It computes a·conj(b) / |b|², then runs a shift-subtract divider on the real and imaginary numerators in parallel against the shared real denominator. A valid/ready handshake is used on both sides, with constant latency and one operation in flight.

---
 rtl/fxp_pkg.sv | 29 ++
 rtl/compdiv_core.sv | 70 +++++++
 rtl/compdiv_eq.sv | 223 ++++++++++++++++++++++
 tb/tb_compdiv_eq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared fixed-point definitions for the receive equaliser
//                blocks. Holds the default Q4.12 geometry, the Q-format
//                saturation codes for that geometry and the state encoding
//                of the sequential complex divider.
//  Revision    : 1.0  initial release
// ============================================================================
package fxp_pkg;

   // Default Q-format geometry: DATA_WIDTH = INT_WIDTH + FRAC_WIDTH
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FRAC_WIDTH = 12;
   localparam int DEF_INT_WIDTH  = 4;

   // Saturation codes for the default geometry
   localparam logic [DEF_DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
   localparam logic [DEF_DATA_WIDTH-1:0] Q_MIN = 16'h8000;

   // Divider control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : fxp_pkg
`default_nettype wire

// File: rtl/compdiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : compdiv_core
//  Description : Unsigned restoring divider datapath. Divides
//                (i_mag << SHIFT) by i_den, one quotient bit per i_step,
//                MSB first, producing QBITS quotient bits. The caller must
//                guarantee the quotient fits in QBITS bits; otherwise the
//                quotient is meaningless and must be overridden upstream.
//  Ports       : i_clk, i_rst_n  clock, asynchronous active-low reset
//                i_load          capture i_mag, clear quotient
//                i_step          perform one restoring iteration
//                i_mag           unsigned dividend magnitude (before shift)
//                i_den           unsigned divisor, held stable while stepping
//                o_q_nxt         quotient including the bit of this step
//  Revision    : 1.0  initial release
// ============================================================================
module compdiv_core #(
   parameter int MAG_W = 33,
   parameter int SHIFT = 12,
   parameter int QBITS = 15
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [MAG_W-1:0] i_mag,
   input  logic [MAG_W-1:0] i_den,
   output logic [QBITS-1:0] o_q_nxt
);

   localparam int C_DVD_W = MAG_W + SHIFT;
   localparam int C_HI_W  = C_DVD_W - QBITS;

   logic [C_DVD_W-1:0] w_dividend;
   logic [MAG_W:0]     w_trial;
   logic [MAG_W-1:0]   w_diff;
   logic               w_ge;

   logic [MAG_W-1:0]   r_rem;
   logic [QBITS-1:0]   r_low;
   logic [QBITS-2:0]   r_q;

   assign w_dividend = {i_mag, {SHIFT{1'b0}}};

   // The bits above the quotient window seed the partial remainder; the
   // window bits are shifted in one per iteration.
   assign w_trial = {r_rem, r_low[QBITS-1]};
   assign w_ge    = (w_trial >= {1'b0, i_den});
   // Only used when w_ge, in which case the difference is below i_den.
   assign w_diff  = w_trial[MAG_W-1:0] - i_den;
   assign o_q_nxt = {r_q, w_ge};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rem <= '0;
         r_low <= '0;
         r_q   <= '0;
      end else if (i_load) begin
         r_rem <= {{(MAG_W-C_HI_W){1'b0}}, w_dividend[C_DVD_W-1:QBITS]};
         r_low <= w_dividend[QBITS-1:0];
         r_q   <= '0;
      end else if (i_step) begin
         r_rem <= w_ge ? w_diff : w_trial[MAG_W-1:0];
         r_low <= {r_low[QBITS-2:0], 1'b0};
         r_q   <= o_q_nxt[QBITS-2:0];
      end
   end

endmodule : compdiv_core
`default_nettype wire

// File: rtl/compdiv_eq.sv
`default_nettype none
// ============================================================================
//  Module      : compdiv_eq
//  Description : Sequential signed fixed-point complex divider o = a / b,
//                computed as a*conj(b) / |b|^2 with two restoring dividers
//                (re, im) sharing the real denominator. One operation in
//                flight, valid/ready on both sides, constant latency.
//  Ports       : i_clk, i_rst_n          clock, asynchronous active-low reset
//                i_valid / o_ready       operand handshake
//                i_a_re, i_a_im          signed dividend
//                i_b_re, i_b_im          signed divisor
//                o_valid / i_ready       result handshake
//                o_res_re, o_res_im      signed quotient
//                o_sat                   a component saturated
//                o_div_zero              divisor was 0+0j
//  Config      : COMPDIV_ROUND_EN -- one extra iteration, result rounded
//                half away from zero (latency +1). Undefined: truncation.
//  Revision    : 1.0  initial release
// ============================================================================
module compdiv_eq
   import fxp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int INT_WIDTH  = DEF_INT_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic signed [DATA_WIDTH-1:0] i_a_re,
   input  logic signed [DATA_WIDTH-1:0] i_a_im,
   input  logic signed [DATA_WIDTH-1:0] i_b_re,
   input  logic signed [DATA_WIDTH-1:0] i_b_im,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic        [DATA_WIDTH-1:0] o_res_re,
   output logic        [DATA_WIDTH-1:0] o_res_im,
   output logic                         o_sat,
   output logic                         o_div_zero
);

   localparam int C_NUM_W  = 2*DATA_WIDTH + 1;
   // Quotient magnitude >= 2^(DATA_WIDTH-1) LSB  <=>  |num| >= den << C_OVF_SH
   localparam int C_OVF_SH = INT_WIDTH - 1;
`ifdef COMPDIV_ROUND_EN
   localparam int C_NSTEPS = DATA_WIDTH;
   localparam int C_SHIFT  = FRAC_WIDTH + 1;
`else
   localparam int C_NSTEPS = DATA_WIDTH - 1;
   localparam int C_SHIFT  = FRAC_WIDTH;
`endif
   localparam int C_CNT_W  = $clog2(C_NSTEPS + 1);
   localparam logic [DATA_WIDTH-1:0] C_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] C_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // ---------------------------------------------------------------------
   // Operand products (evaluated on the accept edge only)
   // ---------------------------------------------------------------------
   logic signed [C_NUM_W-1:0] w_are, w_aim, w_bre, w_bim;
   logic signed [C_NUM_W-1:0] w_num_re, w_num_im;
   logic        [C_NUM_W-1:0] w_den, w_mag_re, w_mag_im;
   logic                      w_ovf_re, w_ovf_im;

   assign w_are    = C_NUM_W'(i_a_re);
   assign w_aim    = C_NUM_W'(i_a_im);
   assign w_bre    = C_NUM_W'(i_b_re);
   assign w_bim    = C_NUM_W'(i_b_im);
   assign w_num_re = w_are*w_bre + w_aim*w_bim;
   assign w_num_im = w_aim*w_bre - w_are*w_bim;
   assign w_den    = $unsigned(w_bre*w_bre + w_bim*w_bim);
   assign w_mag_re = w_num_re[C_NUM_W-1] ? $unsigned(-w_num_re) : $unsigned(w_num_re);
   assign w_mag_im = w_num_im[C_NUM_W-1] ? $unsigned(-w_num_im) : $unsigned(w_num_im);
   assign w_ovf_re = ({{C_OVF_SH{1'b0}}, w_mag_re} >= {w_den, {C_OVF_SH{1'b0}}});
   assign w_ovf_im = ({{C_OVF_SH{1'b0}}, w_mag_im} >= {w_den, {C_OVF_SH{1'b0}}});

   // ---------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------
   state_t               r_state, w_state_nxt;
   logic [C_CNT_W-1:0]   r_cnt;
   logic                 w_accept, w_load, w_step, w_last;

   // Count 0 loads the dividers, counts 1..C_NSTEPS are the iterations.
   assign w_accept = (r_state == IDLE) && i_valid;
   assign w_load   = (r_state == DIV) && (r_cnt == '0);
   assign w_step   = (r_state == DIV) && (r_cnt != '0);
   assign w_last   = (r_state == DIV) && (r_cnt == C_CNT_W'(C_NSTEPS));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) w_state_nxt = DIV;
         end
         DIV: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Registered operands and dividers
   // ---------------------------------------------------------------------
   logic [C_NUM_W-1:0]  r_mag_re, r_mag_im, r_den;
   logic                r_neg_re, r_neg_im, r_ovf_re, r_ovf_im, r_zero;
   logic [C_NSTEPS-1:0] w_q_re, w_q_im;

   compdiv_core #(
      .MAG_W (C_NUM_W),
      .SHIFT (C_SHIFT),
      .QBITS (C_NSTEPS)
   ) u_core_re (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_mag   (r_mag_re),
      .i_den   (r_den),
      .o_q_nxt (w_q_re)
   );

   compdiv_core #(
      .MAG_W (C_NUM_W),
      .SHIFT (C_SHIFT),
      .QBITS (C_NSTEPS)
   ) u_core_im (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_mag   (r_mag_im),
      .i_den   (r_den),
      .o_q_nxt (w_q_im)
   );

   // Applies rounding (if built in), saturation and sign to a quotient
   // magnitude. Returns {sat, result}.
   function automatic logic [DATA_WIDTH:0] f_finish(
      input logic [C_NSTEPS-1:0] q,
      input logic                neg,
      input logic                ovf
   );
      logic [DATA_WIDTH-1:0] mag;
      logic                  sat;
`ifdef COMPDIV_ROUND_EN
      // LSB of q is the half bit; a carry into the sign position saturates.
      mag = {1'b0, q[C_NSTEPS-1:1]} + {{(DATA_WIDTH-1){1'b0}}, q[0]};
`else
      mag = {1'b0, q};
`endif
      sat = ovf | mag[DATA_WIDTH-1];
      if (sat) return {1'b1, (neg ? C_SAT_MIN : C_SAT_MAX)};
      return {1'b0, (neg ? (~mag + 1'b1) : mag)};
   endfunction

   logic [DATA_WIDTH:0] w_fin_re, w_fin_im;
   assign w_fin_re = f_finish(w_q_re, r_neg_re, r_ovf_re);
   assign w_fin_im = f_finish(w_q_im, r_neg_im, r_ovf_im);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_mag_re   <= '0;
         r_mag_im   <= '0;
         r_den      <= '0;
         r_neg_re   <= 1'b0;
         r_neg_im   <= 1'b0;
         r_ovf_re   <= 1'b0;
         r_ovf_im   <= 1'b0;
         r_zero     <= 1'b0;
         o_res_re   <= '0;
         o_res_im   <= '0;
         o_sat      <= 1'b0;
         o_div_zero <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_mag_re <= w_mag_re;
            r_mag_im <= w_mag_im;
            r_den    <= w_den;
            r_neg_re <= w_num_re[C_NUM_W-1];
            r_neg_im <= w_num_im[C_NUM_W-1];
            r_ovf_re <= w_ovf_re;
            r_ovf_im <= w_ovf_im;
            r_zero   <= (w_den == '0);
         end else if (r_state == DIV) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
         end

         // Results are captured on the final iteration edge, using the
         // quotient bit being produced on that same edge.
         if (w_last) begin
            if (r_zero) begin
               o_res_re   <= '0;
               o_res_im   <= '0;
               o_sat      <= 1'b0;
               o_div_zero <= 1'b1;
            end else begin
               o_res_re   <= w_fin_re[DATA_WIDTH-1:0];
               o_res_im   <= w_fin_im[DATA_WIDTH-1:0];
               o_sat      <= w_fin_re[DATA_WIDTH] | w_fin_im[DATA_WIDTH];
               o_div_zero <= 1'b0;
            end
         end
      end
   end

endmodule : compdiv_eq
`default_nettype wire

// File: tb/tb_compdiv_eq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compdiv_eq
//  Description : Self-checking bench for compdiv_eq. Directed vectors,
//                randomized operands against an integer reference model,
//                backpressure, mid-operation reset and back-to-back issue.
//                Honours COMPDIV_ROUND_EN for expected latency and rounding.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_compdiv_eq;

`ifdef COMPDIV_ROUND_EN
   localparam int LAT = 17;
`else
   localparam int LAT = 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic        ready_i;
   logic [15:0] a_re, a_im, b_re, b_im;
   logic        o_ready, o_valid, o_sat, o_div_zero;
   logic [15:0] o_res_re, o_res_im;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   compdiv_eq dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (valid_i),
      .o_ready    (o_ready),
      .i_a_re     (a_re),
      .i_a_im     (a_im),
      .i_b_re     (b_re),
      .i_b_im     (b_im),
      .o_valid    (o_valid),
      .i_ready    (ready_i),
      .o_res_re   (o_res_re),
      .o_res_im   (o_res_im),
      .o_sat      (o_sat),
      .o_div_zero (o_div_zero)
   );

   // ---------------- reference model ----------------
   // Quotient of one component from the exact integer numerator/denominator.
   function automatic logic [16:0] ref_comp(input longint n, input longint d);
      longint m, q;
      m = (n < 0) ? -n : n;
`ifdef COMPDIV_ROUND_EN
      q = (m * 8192) / d;
      q = (q + 1) / 2;
`else
      q = (m * 4096) / d;
`endif
      if (q >= 32768) return {1'b1, ((n < 0) ? 16'h8000 : 16'h7FFF)};
      return {1'b0, ((n < 0) ? 16'(-q) : 16'(q))};
   endfunction

   task automatic ref_div(input logic [15:0] ar, ai, br, bi,
                          output logic [15:0] er, ei, output logic es, ed);
      longint xr, xi, yr, yi, nr, ni, d;
      logic [16:0] cr, ci;
      xr = longint'($signed(ar)); xi = longint'($signed(ai));
      yr = longint'($signed(br)); yi = longint'($signed(bi));
      nr = xr*yr + xi*yi;
      ni = xi*yr - xr*yi;
      d  = yr*yr + yi*yi;
      if (d == 0) begin
         er = 16'h0; ei = 16'h0; es = 1'b0; ed = 1'b1;
      end else begin
         cr = ref_comp(nr, d);
         ci = ref_comp(ni, d);
         er = cr[15:0]; ei = ci[15:0]; es = cr[16] | ci[16]; ed = 1'b0;
      end
   endtask

   // ---------------- stimulus helper (no checking) ----------------
   task automatic do_op(input logic [15:0] ar, ai, br, bi, input bit handshake,
                        output logic [15:0] rr, ri, output logic rs, rd,
                        output int lat, output logic rdy);
      @(negedge clk);
      a_re = ar; a_im = ai; b_re = br; b_im = bi;
      valid_i = 1'b1;
      rdy = o_ready;
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = 0;
      while (o_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rr = o_res_re; ri = o_res_im; rs = o_sat; rd = o_div_zero;
      if (handshake) begin
         ready_i = 1'b1;
         @(posedge clk); #1;
         ready_i = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({o_ready, o_valid} !== 2'b10)
         $display("FAIL reset_hs: got ready/valid=%b required 10", {o_ready, o_valid});
      else n_pass++;
      n_checks++;
      if ({o_res_re, o_res_im, o_sat, o_div_zero} !== 34'h0)
         $display("FAIL reset_data: got %h %h sat=%b dz=%b required all 0",
                  o_res_re, o_res_im, o_sat, o_div_zero);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] ar, ai, br, bi, er, ei;
      logic        es, ed;
   } vec_t;

   task automatic test_directed;
      vec_t v[7];
      logic [15:0] rr, ri, q23p, q23n;
      logic rs, rd, rdy;
      int lat;
`ifdef COMPDIV_ROUND_EN
      q23p = 16'h0AAB; q23n = 16'hF555;
`else
      q23p = 16'h0AAA; q23n = 16'hF556;
`endif
      v[0] = '{16'h1000, 16'h0000, 16'h2000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0};
      v[1] = '{16'h1000, 16'h1000, 16'h0000, 16'h1000, 16'h1000, 16'hF000, 1'b0, 1'b0};
      v[2] = '{16'h2000, 16'h0000, 16'h3000, 16'h0000, q23p,     16'h0000, 1'b0, 1'b0};
      v[3] = '{16'hE000, 16'h0000, 16'h3000, 16'h0000, q23n,     16'h0000, 1'b0, 1'b0};
      v[4] = '{16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
      v[5] = '{16'h7000, 16'h0000, 16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
      v[6] = '{16'h9000, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         do_op(v[i].ar, v[i].ai, v[i].br, v[i].bi, 1'b1, rr, ri, rs, rd, lat, rdy);
         n_checks++;
         if ({rr, ri, rs, rd} !== {v[i].er, v[i].ei, v[i].es, v[i].ed})
            $display("FAIL directed[%0d]: got %h %h sat=%b dz=%b required %h %h sat=%b dz=%b",
                     i, rr, ri, rs, rd, v[i].er, v[i].ei, v[i].es, v[i].ed);
         else n_pass++;
         n_checks++;
         if (lat !== LAT) $display("FAIL directed_lat[%0d]: got %0d required %0d", i, lat, LAT);
         else n_pass++;
         n_checks++;
         if ({rdy, o_valid, o_ready} !== 3'b101)
            $display("FAIL directed_hs[%0d]: got rdy/valid/ready=%b required 101",
                     i, {rdy, o_valid, o_ready});
         else n_pass++;
      end
   endtask

   task automatic test_random;
      logic [15:0] ar, ai, br, bi, rr, ri, er, ei;
      logic rs, rd, es, ed, rdy;
      int lat, mode;
      for (int i = 0; i < 30; i++) begin
         ar = 16'($urandom); ai = 16'($urandom);
         mode = $urandom_range(0, 4);
         case (mode)
            0:       begin br = 16'($urandom); bi = 16'($urandom); end
            1:       begin br = 16'($urandom_range(0, 16'h01FF)); bi = 16'($urandom_range(0, 16'h00FF)); end
            2:       begin br = 16'($urandom) | 16'h4000; bi = 16'($urandom); ar = 16'($signed(ar) >>> 2); end
            3:       begin br = 16'h0000; bi = 16'h0000; end
            default: begin br = 16'($urandom); bi = 16'h0000; ai = 16'h0000; end
         endcase
         ref_div(ar, ai, br, bi, er, ei, es, ed);
         do_op(ar, ai, br, bi, 1'b1, rr, ri, rs, rd, lat, rdy);
         n_checks++;
         if ({rr, ri, rs, rd} !== {er, ei, es, ed})
            $display("FAIL random[%0d] a=%h,%h b=%h,%h: got %h %h sat=%b dz=%b required %h %h sat=%b dz=%b",
                     i, ar, ai, br, bi, rr, ri, rs, rd, er, ei, es, ed);
         else n_pass++;
         n_checks++;
         if (lat !== LAT) $display("FAIL random_lat[%0d]: got %0d required %0d", i, lat, LAT);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] rr, ri, er, ei;
      logic rs, rd, es, ed, rdy;
      int lat;
      ref_div(16'h2000, 16'hF000, 16'h1000, 16'h0800, er, ei, es, ed);
      do_op(16'h2000, 16'hF000, 16'h1000, 16'h0800, 1'b0, rr, ri, rs, rd, lat, rdy);
      n_checks++;
      if ({rr, ri, rs, rd} !== {er, ei, es, ed})
         $display("FAIL bp_result: got %h %h sat=%b dz=%b required %h %h sat=%b dz=%b",
                  rr, ri, rs, rd, er, ei, es, ed);
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         a_re = 16'h3000; a_im = 16'h1234; b_re = 16'h0800; b_im = 16'h0400;
         valid_i = 1'b1;
         @(posedge clk); #1;
         n_checks++;
         if ({o_valid, o_ready} !== 2'b10)
            $display("FAIL bp_hs[%0d]: got valid/ready=%b required 10", c, {o_valid, o_ready});
         else n_pass++;
         n_checks++;
         if ({o_res_re, o_res_im, o_sat, o_div_zero} !== {er, ei, es, ed})
            $display("FAIL bp_hold[%0d]: got %h %h sat=%b dz=%b required %h %h sat=%b dz=%b",
                     c, o_res_re, o_res_im, o_sat, o_div_zero, er, ei, es, ed);
         else n_pass++;
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      n_checks++;
      if ({o_valid, o_ready} !== 2'b01)
         $display("FAIL bp_release: got valid/ready=%b required 01", {o_valid, o_ready});
      else n_pass++;
      // A stray accept during DONE would show up here as a wrong latency.
      ref_div(16'h1800, 16'h0000, 16'h1000, 16'h0000, er, ei, es, ed);
      do_op(16'h1800, 16'h0000, 16'h1000, 16'h0000, 1'b1, rr, ri, rs, rd, lat, rdy);
      n_checks++;
      if ({rr, ri, rs, rd, lat} !== {er, ei, es, ed, LAT})
         $display("FAIL bp_next: got %h %h sat=%b dz=%b lat=%0d required %h %h sat=%b dz=%b lat=%0d",
                  rr, ri, rs, rd, lat, er, ei, es, ed, LAT);
      else n_pass++;
   endtask

   task automatic test_reset_midop;
      logic [15:0] rr, ri;
      logic rs, rd, rdy;
      int lat;
      @(negedge clk);
      a_re = 16'h7000; a_im = 16'h0000; b_re = 16'h0100; b_im = 16'h0000;
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_ready} !== 2'b01)
         $display("FAIL rst_mid_hs: got valid/ready=%b required 01", {o_valid, o_ready});
      else n_pass++;
      n_checks++;
      if ({o_res_re, o_res_im, o_sat, o_div_zero} !== 34'h0)
         $display("FAIL rst_mid_data: got %h %h sat=%b dz=%b required all 0",
                  o_res_re, o_res_im, o_sat, o_div_zero);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      do_op(16'h1000, 16'h1000, 16'h0000, 16'h1000, 1'b1, rr, ri, rs, rd, lat, rdy);
      n_checks++;
      if ({rr, ri, rs, rd, lat} !== {16'h1000, 16'hF000, 1'b0, 1'b0, LAT})
         $display("FAIL rst_mid_next: got %h %h sat=%b dz=%b lat=%0d required 1000 f000 sat=0 dz=0 lat=%0d",
                  rr, ri, rs, rd, lat, LAT);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] rr, ri, er, ei;
      logic rs, rd, es, ed, rdy;
      int lat;
      do_op(16'h0C00, 16'h0400, 16'h1000, 16'hF000, 1'b0, rr, ri, rs, rd, lat, rdy);
      ref_div(16'h0C00, 16'h0400, 16'h1000, 16'hF000, er, ei, es, ed);
      n_checks++;
      if ({rr, ri, rs, rd} !== {er, ei, es, ed})
         $display("FAIL b2b_first: got %h %h sat=%b dz=%b required %h %h sat=%b dz=%b",
                  rr, ri, rs, rd, er, ei, es, ed);
      else n_pass++;
      // New operands offered on the hand-off edge must wait one more edge.
      @(negedge clk);
      a_re = 16'hD000; a_im = 16'h0800; b_re = 16'h0600; b_im = 16'h0200;
      valid_i = 1'b1;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      n_checks++;
      if ({o_valid, o_ready} !== 2'b01)
         $display("FAIL b2b_handoff: got valid/ready=%b required 01", {o_valid, o_ready});
      else n_pass++;
      @(posedge clk); #1;
      valid_i = 1'b0;
      n_checks++;
      if (o_ready !== 1'b0) $display("FAIL b2b_accept: got ready=%b required 0", o_ready);
      else n_pass++;
      lat = 0;
      while (o_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      ref_div(16'hD000, 16'h0800, 16'h0600, 16'h0200, er, ei, es, ed);
      n_checks++;
      if ({o_res_re, o_res_im, o_sat, o_div_zero, lat} !== {er, ei, es, ed, LAT})
         $display("FAIL b2b_second: got %h %h sat=%b dz=%b lat=%0d required %h %h sat=%b dz=%b lat=%0d",
                  o_res_re, o_res_im, o_sat, o_div_zero, lat, er, ei, es, ed, LAT);
      else n_pass++;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_compdiv_eq
`default_nettype wire
